// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// registered occupancy count, 1-cycle read latency and sticky error flags.
module fifo_sync_prog #(
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned ASIZE    = 4,
    parameter int unsigned AF_LEVEL = 2**ASIZE - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             clr_err,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned    DEPTH  = 2**ASIZE;
    localparam logic [ASIZE:0] AF_CNT = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_CNT = (ASIZE+1)'(AE_LEVEL);

    if (AF_LEVEL > DEPTH) begin : g_af_check
        $error("AF_LEVEL must not exceed the FIFO depth");
    end
    if (AE_LEVEL >= DEPTH) begin : g_ae_check
        $error("AE_LEVEL must be below the FIFO depth");
    end

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rvalid_q;
    logic [DSIZE-1:0] rdata_q;
    logic             wr_en, rd_en;

    always_comb begin
        wr_en       = winc & ~wfull_q;
        rd_en       = rinc & ~rempty_q;
        wptr_d      = wptr_q + (ASIZE+1)'(wr_en);
        rptr_d      = rptr_q + (ASIZE+1)'(rd_en);
        // Flags and count come from the next pointers so they are valid right after the edge.
        rempty_d    = (wptr_d == rptr_d);
        wfull_d     = (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]) &&
                      (wptr_d[ASIZE] != rptr_d[ASIZE]);
        count_d     = wptr_d - rptr_d;
        // A new error wins over a coincident clear.
        overflow_d  = (winc & wfull_q) | (overflow_q & ~clr_err);
        underflow_d = (rinc & rempty_q) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wfull_q     <= 1'b0;
            rempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            wfull_q     <= wfull_d;
            rempty_q    <= rempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rvalid_q    <= rd_en;
            if (rd_en) begin
                rdata_q <= mem[rptr_q[ASIZE-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign wfull         = wfull_q;
    assign rempty        = rempty_q;
    assign count         = count_q;
    assign walmost_full  = (count_q >= AF_CNT);
    assign ralmost_empty = (count_q <= AE_CNT);
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Scoreboard bench for fifo_sync_prog at default parameters: a queue model
// tracks stored words and expected read data is compared when rvalid arrives.
module tb_fifo_sync_prog;

    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata;
    logic       winc, rinc, clr_err;
    logic [7:0] rdata;
    logic       rvalid, wfull, rempty, walmost_full, ralmost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];   // model of stored words
    logic [7:0] sbq[$];  // expected read data, awaiting rvalid
    logic       m_ovf, m_unf;

    fifo_sync_prog dut (
        .clk          (clk),
        .rst          (rst),
        .wdata        (wdata),
        .winc         (winc),
        .rinc         (rinc),
        .clr_err      (clr_err),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .wfull        (wfull),
        .rempty       (rempty),
        .walmost_full (walmost_full),
        .ralmost_empty(ralmost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status(input logic exp_rvalid);
        int c;
        c = mq.size();
        check_eq("count", 32'(count), 32'(c));
        check_eq("rempty", 32'(rempty), 32'(c == 0));
        check_eq("wfull", 32'(wfull), 32'(c == DEPTH));
        check_eq("walmost_full", 32'(walmost_full), 32'(c >= AF));
        check_eq("ralmost_empty", 32'(ralmost_empty), 32'(c <= AE));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_unf));
        check_eq("rvalid", 32'(rvalid), 32'(exp_rvalid));
        if (rvalid && sbq.size() > 0) begin
            check_eq("rdata", 32'(rdata), 32'(sbq.pop_front()));
        end
    endtask

    // One clock of stimulus; model is advanced from its pre-edge state.
    task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic clr);
        logic full, empty, rd_ok;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        winc = w; wdata = wd; rinc = r; clr_err = clr;
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
        rd_ok = r && !empty;
        if (rd_ok) sbq.push_back(mq.pop_front());
        if (w && !full) mq.push_back(wd);
        m_ovf = (w && full) || (m_ovf && !clr);
        m_unf = (r && empty) || (m_unf && !clr);
        check_status(rd_ok);
    endtask

    task automatic do_reset(input logic w);
        rst = 1'b1; winc = w; wdata = 8'hEE; rinc = 1'b1; clr_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
        mq.delete();
        sbq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_status(1'b0);
        check_eq("rdata_reset", 32'(rdata), 32'h0);
    endtask

    initial begin
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        // Fill with 0x01..0x10, then drain in order
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check_eq("full_after_16", 32'(wfull), 32'h1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("empty_after_drain", 32'(rempty), 32'h1);

        // Overflow: 17th write of 0xAA, then read+write on full, drain, clear
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check_eq("ovf_set", 32'(overflow), 32'h1);
        step(1'b1, 8'hAB, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("ovf_cleared", 32'(overflow), 32'h0);

        // Underflow with coincident write of 0x55
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check_eq("unf_set", 32'(underflow), 32'h1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("read_55", 32'(rdata), 32'h55);
        // New error coinciding with clear keeps the flag
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("unf_err_beats_clr", 32'(underflow), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Hold count 8 with simultaneous traffic across pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        check_eq("count_hold8", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset mid-operation with winc held, then a fresh word
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0);
        do_reset(1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("read_77", 32'(rdata), 32'h77);

        // Random mixed traffic
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_prog.md
FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ASIZE, default 4, address width; depth = 2**ASIZE words.
REQ-003 SHALL have parameter AF_LEVEL, default 2**ASIZE-2, almost-full threshold in words.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in words.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port wdata, input, DSIZE, write data.
REQ-008 SHALL have port winc, input, 1, write request.
REQ-009 SHALL have port rinc, input, 1, read request.
REQ-010 SHALL have port clr_err, input, 1, clears sticky error flags.
REQ-011 SHALL have port rdata, output, DSIZE, registered read data.
REQ-012 SHALL have port rvalid, output, 1, rdata valid strobe.
REQ-013 SHALL have port wfull, output, 1, FIFO full.
REQ-014 SHALL have port rempty, output, 1, FIFO empty.
REQ-015 SHALL have port walmost_full, output, 1, occupancy >= AF_LEVEL.
REQ-016 SHALL have port ralmost_empty, output, 1, occupancy <= AE_LEVEL.
REQ-017 SHALL have port count, output, ASIZE+1, current occupancy 0..2**ASIZE.
REQ-018 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.
REQ-019 Clock and reset: one clock; reset synchronous and active-high; ports named clk and rst.

Function
REQ-020 Storage SHALL be a 2**ASIZE x DSIZE array addressed by ASIZE-bit write/read addresses taken from (ASIZE+1)-bit binary pointers.
REQ-021 Write accepted iff winc=1 and wfull=0; accepted write stores wdata at waddr and increments write pointer at the same edge.
REQ-022 Read accepted iff rinc=1 and rempty=0; accepted read registers mem[raddr] into rdata and increments read pointer; rdata and rvalid=1 appear the cycle after rinc (1-cycle latency).
REQ-023 rvalid SHALL be 0 in every cycle following a non-accepted read; rdata SHALL hold its last value when no read is accepted.
REQ-024 Pointers SHALL wrap modulo 2**(ASIZE+1); wrap bit (MSB) distinguishes full from empty.
REQ-025 rempty=1 iff wptr==rptr; wfull=1 iff addresses equal and MSBs differ; both flags registered, valid the cycle after the updating edge.
REQ-026 count SHALL equal wptr-rptr modulo 2**(ASIZE+1), registered; +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-027 walmost_full and ralmost_empty SHALL be derived from the registered count of the same cycle.
REQ-028 Simultaneous winc and rinc when neither full nor empty: both accepted, count unchanged.
REQ-029 winc while full: write dropped, memory and pointers unchanged, overflow set to 1 the next cycle, even if rinc is asserted the same cycle (the read is still accepted).
REQ-030 rinc while empty: read dropped, rvalid=0, underflow set to 1 the next cycle, even if winc is asserted the same cycle (the write is still accepted).
REQ-031 overflow/underflow SHALL remain 1 until clr_err=1 or rst=1; if a new error and clr_err coincide, the flag SHALL be 1.
REQ-032 Elaboration SHALL be rejected if AF_LEVEL > 2**ASIZE or AE_LEVEL >= 2**ASIZE.

Reset
REQ-033 With rst=1 at a rising edge: pointers=0, count=0, rempty=1, wfull=0, walmost_full=0, ralmost_empty=1, rvalid=0, rdata=0, overflow=0, underflow=0.
REQ-034 rst SHALL override winc, rinc and clr_err in the same cycle; memory contents need not be cleared.
REQ-035 Reset mid-operation discards all stored words; the first read after reset returns the first word written after reset.

Verification
REQ-036 Defaults: write 0x01..0x10 (16 writes) -> wfull=1 after the 16th, count=16, walmost_full=1 from count=14; read 16 -> rdata 0x01..0x10 in order, each 1 cycle after rinc, rempty=1 at end.
REQ-037 Full FIFO plus a 17th write of 0xAA -> overflow=1, count=16; draining returns no 0xAA; clr_err pulse -> overflow=0.
REQ-038 Empty FIFO, rinc=1 and winc=1 with 0x55 together -> underflow=1, rvalid=0, count=1; next read returns 0x55.
REQ-039 Count 8, simultaneous read+write for 40 cycles (pointer wrap) -> count stays 8, data order preserved.
REQ-040 Write 5 words, assert rst for 1 cycle with winc=1 -> count=0, rempty=1, all flags at reset values; write 0x77, then read -> rdata=0x77.
REQ-041 Count crossing AE_LEVEL=2: ralmost_empty=1 at counts 0,1,2 and 0 at count 3.
